// File: rtl/updown_counter_sequencer_pkg.sv
// Purpose: shared encodings and default sizes for the up/down counter command sequencer.
// Contents: op codes, completion status codes, FSM state encoding, width defaults.
package updown_counter_sequencer_pkg;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned REP_W_DEF   = 8;
  localparam int unsigned GAP_CYC_DEF = 2;
  localparam int unsigned OP_W        = 2;
  localparam int unsigned ST_W        = 2;
  // Wide enough for the largest legal gap length (15).
  localparam int unsigned GAP_W       = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DN   = 2'd2,
    OP_ILL  = 2'd3
  } op_e;

  typedef enum logic [ST_W-1:0] {
    ST_OK      = 2'd0,
    ST_ABORTED = 2'd1,
    ST_ILLEGAL = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/updown_counter_sequencer_if.sv
// Purpose: bundles the sequencer's command handshake, run controls and counter-side signals.
// Modports:
//   master - command/control source (upstream logic, counter expiry feedback)
//   slave  - the sequencer itself
interface updown_counter_sequencer_if
  import updown_counter_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned REP_W = REP_W_DEF
);

  // Command handshake
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [CNT_W-1:0] cmd_preset;
  logic [REP_W-1:0] cmd_reps;

  // Run controls and counter feedback
  logic             hold;
  logic             abort;
  logic             ctr_expired;

  // Counter control outputs
  logic             new_cntr_preset;
  logic [CNT_W-1:0] new_cntr_preset_value;
  logic             enable_cnt_up;
  logic             enable_cnt_dn;
  logic             pause_counting;

  // Status outputs
  logic             busy;
  logic             done;
  logic [ST_W-1:0]  done_status;

  modport master (
    output cmd_valid, cmd_op, cmd_preset, cmd_reps, hold, abort, ctr_expired,
    input  cmd_ready, new_cntr_preset, new_cntr_preset_value, enable_cnt_up,
           enable_cnt_dn, pause_counting, busy, done, done_status
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_preset, cmd_reps, hold, abort, ctr_expired,
    output cmd_ready, new_cntr_preset, new_cntr_preset_value, enable_cnt_up,
           enable_cnt_dn, pause_counting, busy, done, done_status
  );

endinterface

// File: rtl/updown_seq_expiry_tracker.sv
// Purpose: qualifies counter expiry flags and counts them toward the commanded repeat count.
// Ports:
//   clk, resetb        clock, async active-low reset
//   i_clear            clear the expiry count (start of a run)
//   i_active           sequencer is in RUN
//   i_ctr_expired      raw expiry flag from the counter
//   i_pause            pause_counting as currently driven to the counter
//   i_reps             repeat target (already forced to >= 1)
//   o_last_expiry_c    combinational pulse: this cycle's event completes the run
module updown_seq_expiry_tracker
  import updown_counter_sequencer_pkg::*;
#(
  parameter int unsigned REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             i_clear,
  input  logic             i_active,
  input  logic             i_ctr_expired,
  input  logic             i_pause,
  input  logic [REP_W-1:0] i_reps,
  output logic             o_last_expiry_c
);

  localparam int unsigned CMP_W = REP_W + 1;

  logic             r_pause_prev;
  logic [REP_W-1:0] r_exp_cnt;
  logic             w_event;
  logic [CMP_W-1:0] w_cnt_inc;

  // A flag seen right after a paused cycle is stale and must not count.
  assign w_event         = i_active & i_ctr_expired & ~r_pause_prev;
  // Compare one bit wider so the terminal check can never alias on wrap.
  assign w_cnt_inc       = {1'b0, r_exp_cnt} + CMP_W'(1);
  assign o_last_expiry_c = w_event & (w_cnt_inc == {1'b0, i_reps});

  // Delayed pause and expiry count
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_pause_prev <= 1'b0;
      r_exp_cnt    <= '0;
    end else begin
      r_pause_prev <= i_pause;
      if (i_clear) begin
        r_exp_cnt <= '0;
      end else if (w_event) begin
        r_exp_cnt <= w_cnt_inc[REP_W-1:0];
      end
    end
  end

endmodule

// File: rtl/updown_counter_sequencer.sv
// Purpose: accepts LOAD/UP/DN commands and drives preset, enables and pause of an up/down
//          counter, counting expiries until the repeat target, with an enable-low gap after
//          each run.
// Ports:
//   clk, resetb   clock, async active-low reset
//   bus (slave)   command handshake, hold/abort, ctr_expired in; counter controls,
//                 busy, done, done_status out
module updown_counter_sequencer
  import updown_counter_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned REP_W   = REP_W_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      resetb,
  updown_counter_sequencer_if.slave bus
);

  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic             r_live;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [REP_W-1:0] r_reps, w_reps_nxt;
  logic             r_dir_up, w_dir_up_nxt;
  logic             r_preset, w_preset_nxt;
  logic [CNT_W-1:0] r_preset_val, w_preset_val_nxt;
  logic             r_en_up, w_en_up_nxt;
  logic             r_en_dn, w_en_dn_nxt;
  logic             r_pause, w_pause_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [ST_W-1:0]  r_status, w_status_nxt;

  logic w_cmd_ready;
  logic w_accept;
  logic w_clear;
  logic w_in_run;
  logic w_last_expiry;

  // r_live keeps cmd_ready low in reset and until the first edge after release.
  assign w_cmd_ready = r_live & (r_state == S_IDLE);
  assign w_accept    = bus.cmd_valid & w_cmd_ready;
  assign w_in_run    = (r_state == S_RUN);

  updown_seq_expiry_tracker #(
    .REP_W (REP_W)
  ) u_expiry_tracker (
    .clk             (clk),
    .resetb          (resetb),
    .i_clear         (w_clear),
    .i_active        (w_in_run),
    .i_ctr_expired   (bus.ctr_expired),
    .i_pause         (r_pause),
    .i_reps          (r_reps),
    .o_last_expiry_c (w_last_expiry)
  );

  // Next state and next values of all registered outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_reps_nxt       = r_reps;
    w_dir_up_nxt     = r_dir_up;
    w_preset_nxt     = 1'b0;
    w_preset_val_nxt = r_preset_val;
    w_en_up_nxt      = 1'b0;
    w_en_dn_nxt      = 1'b0;
    w_pause_nxt      = 1'b0;
    w_done_nxt       = 1'b0;
    w_status_nxt     = r_status;
    w_clear          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_LOAD: begin
              w_state_nxt      = S_LOAD;
              w_preset_nxt     = 1'b1;
              w_preset_val_nxt = bus.cmd_preset;
              w_done_nxt       = 1'b1;
              w_status_nxt     = ST_OK;
            end
            OP_UP, OP_DN: begin
              w_state_nxt  = S_RUN;
              w_dir_up_nxt = (bus.cmd_op == OP_UP);
              w_en_up_nxt  = (bus.cmd_op == OP_UP);
              w_en_dn_nxt  = (bus.cmd_op == OP_DN);
              w_reps_nxt   = (bus.cmd_reps == '0) ? REP_W'(1) : bus.cmd_reps;
              w_clear      = 1'b1;
            end
            default: begin
              w_state_nxt   = S_GAP;
              w_gap_cnt_nxt = GAP_INIT;
              w_done_nxt    = 1'b1;
              w_status_nxt  = ST_ILLEGAL;
            end
          endcase
        end
      end

      // Strobe and OK are already on the outputs; only an abort changes the exit.
      S_LOAD: begin
        if (bus.abort) begin
          w_state_nxt   = S_GAP;
          w_gap_cnt_nxt = GAP_INIT;
          w_done_nxt    = 1'b1;
          w_status_nxt  = ST_ABORTED;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      // Abort outranks a coincident final expiry.
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt   = S_GAP;
          w_gap_cnt_nxt = GAP_INIT;
          w_done_nxt    = 1'b1;
          w_status_nxt  = ST_ABORTED;
        end else if (w_last_expiry) begin
          w_state_nxt   = S_GAP;
          w_gap_cnt_nxt = GAP_INIT;
          w_done_nxt    = 1'b1;
          w_status_nxt  = ST_OK;
        end else begin
          w_en_up_nxt = r_dir_up;
          w_en_dn_nxt = ~r_dir_up;
          w_pause_nxt = bus.hold;
        end
      end

      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, captured command fields and output registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state      <= S_IDLE;
      r_live       <= 1'b0;
      r_gap_cnt    <= '0;
      r_reps       <= '0;
      r_dir_up     <= 1'b0;
      r_preset     <= 1'b0;
      r_preset_val <= '0;
      r_en_up      <= 1'b0;
      r_en_dn      <= 1'b0;
      r_pause      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_status     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_live       <= 1'b1;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_reps       <= w_reps_nxt;
      r_dir_up     <= w_dir_up_nxt;
      r_preset     <= w_preset_nxt;
      r_preset_val <= w_preset_val_nxt;
      r_en_up      <= w_en_up_nxt;
      r_en_dn      <= w_en_dn_nxt;
      r_pause      <= w_pause_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_status     <= w_status_nxt;
    end
  end

  assign bus.cmd_ready             = w_cmd_ready;
  assign bus.new_cntr_preset       = r_preset;
  assign bus.new_cntr_preset_value = r_preset_val;
  assign bus.enable_cnt_up         = r_en_up;
  assign bus.enable_cnt_dn         = r_en_dn;
  assign bus.pause_counting        = r_pause;
  assign bus.busy                  = r_busy;
  assign bus.done                  = r_done;
  assign bus.done_status           = r_status;

endmodule

// File: tb/tb_updown_counter_sequencer.sv
// Purpose: randomized self-checking bench for updown_counter_sequencer. The expected
//          cycle-by-cycle outputs come from a transaction-level model of each command:
//          qualified expiries are counted against the repeat target, and the done cycle,
//          status and gap length follow from that arithmetic.
module tb_updown_counter_sequencer;
  import updown_counter_sequencer_pkg::*;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned REP_W   = 8;
  localparam int unsigned GAP_CYC = 2;

  logic             clk;
  logic             resetb;
  int               n_checks;
  int               n_errors;
  logic [CNT_W-1:0] last_preset;
  logic [1:0]       last_status;

  updown_counter_sequencer_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();

  updown_counter_sequencer #(
    .CNT_W   (CNT_W),
    .REP_W   (REP_W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rnd(input int pct);
    return 1'($urandom_range(99) < 32'(pct));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic pre, input logic [CNT_W-1:0] val,
                            input logic up, input logic dn, input logic pz, input logic bsy,
                            input logic dne, input logic [1:0] st, input logic rdy);
    check_eq({tag, ".preset"}, 32'(bus.new_cntr_preset), 32'(pre));
    check_eq({tag, ".preset_value"}, 32'(bus.new_cntr_preset_value), 32'(val));
    check_eq({tag, ".en_up"}, 32'(bus.enable_cnt_up), 32'(up));
    check_eq({tag, ".en_dn"}, 32'(bus.enable_cnt_dn), 32'(dn));
    check_eq({tag, ".pause"}, 32'(bus.pause_counting), 32'(pz));
    check_eq({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    check_eq({tag, ".done"}, 32'(bus.done), 32'(dne));
    check_eq({tag, ".status"}, 32'(bus.done_status), 32'(st));
    check_eq({tag, ".ready"}, 32'(bus.cmd_ready), 32'(rdy));
  endtask

  // Offer one command and let it be accepted; returns in the cycle after the accept.
  task automatic send_cmd(input logic [1:0] op, input logic [CNT_W-1:0] pre,
                          input logic [REP_W-1:0] reps);
    int w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check_eq("accept.ready", 32'(bus.cmd_ready), 32'(1'b1));
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_preset  = pre;
    bus.cmd_reps    = reps;
    bus.abort       = rnd(50);
    bus.ctr_expired = rnd(50);
    bus.hold        = 1'b0;
    tick();
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 2'($urandom);
    bus.cmd_preset  = CNT_W'($urandom);
    bus.cmd_reps    = REP_W'($urandom);
    bus.abort       = 1'b0;
    bus.ctr_expired = 1'b0;
  endtask

  // Called in the done cycle (first gap cycle): the rest of the gap, then IDLE.
  task automatic gap_tail(input string tag);
    for (int k = 2; k <= int'(GAP_CYC); k++) begin
      bus.abort       = rnd(50);
      bus.ctr_expired = rnd(50);
      bus.hold        = rnd(50);
      tick();
      check_outs({tag, ".gap"}, 1'b0, last_preset, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, last_status, 1'b0);
    end
    bus.abort       = rnd(50);
    bus.ctr_expired = rnd(50);
    bus.hold        = rnd(50);
    tick();
    check_outs({tag, ".idle"}, 1'b0, last_preset, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_status, 1'b1);
    bus.abort       = 1'b0;
    bus.ctr_expired = 1'b0;
    bus.hold        = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [CNT_W-1:0] pre, input logic abort_it);
    send_cmd(OP_LOAD, pre, REP_W'($urandom));
    last_preset = pre;
    last_status = ST_OK;
    check_outs({tag, ".strobe"}, 1'b1, pre, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ST_OK, 1'b0);
    bus.abort       = abort_it;
    bus.ctr_expired = rnd(50);
    bus.hold        = rnd(50);
    tick();
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    if (abort_it) begin
      last_status = ST_ABORTED;
      check_outs({tag, ".abort"}, 1'b0, pre, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ST_ABORTED, 1'b0);
      gap_tail(tag);
    end else begin
      check_outs({tag, ".after"}, 1'b0, pre, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_OK, 1'b1);
    end
  endtask

  task automatic do_illegal(input string tag);
    send_cmd(OP_ILL, CNT_W'($urandom), REP_W'($urandom));
    last_status = ST_ILLEGAL;
    check_outs({tag, ".done"}, 1'b0, last_preset, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ST_ILLEGAL, 1'b0);
    gap_tail(tag);
  endtask

  // One UP/DN run. Model: pause(next) = hold; an expiry counts only if pause was 0 in the
  // previous cycle; the count reaching max(reps,1) or an abort ends the run next cycle.
  task automatic do_run(input string tag, input logic [1:0] op, input logic [REP_W-1:0] reps,
                        input int hold_pct, input int exp_pct, input int abort_pct,
                        input logic abort_final, input logic burst);
    int   target;
    int   cnt;
    int   j;
    logic p_cur;
    logic p_prev;
    logic h;
    logic e;
    logic a;
    logic ev;
    logic fin;
    logic up_e;
    logic dn_e;
    target = (reps == '0) ? 1 : int'(reps);
    up_e   = (op == OP_UP);
    dn_e   = (op == OP_DN);
    send_cmd(op, CNT_W'($urandom), reps);
    cnt    = 0;
    j      = 1;
    p_cur  = 1'b0;
    p_prev = 1'b0;
    fin    = 1'b0;
    while (!fin) begin
      check_outs({tag, ".run"}, 1'b0, last_preset, up_e, dn_e, p_cur, 1'b1, 1'b0, last_status, 1'b0);
      if (burst) begin
        h = (j >= 2 && j <= 5);
        e = (j >= 4 && j <= 7) ? 1'b1 : ((j < 4) ? 1'b0 : rnd(exp_pct));
      end else begin
        h = rnd(hold_pct);
        e = rnd(exp_pct);
      end
      if (j > 100) begin
        h = 1'b0;
        e = 1'b1;
      end
      ev = e & ~p_prev;
      a  = rnd(abort_pct) | (abort_final & ev & (cnt + 1 == target));
      bus.hold        = h;
      bus.ctr_expired = e;
      bus.abort       = a;
      tick();
      if (a) begin
        last_status = ST_ABORTED;
        fin = 1'b1;
      end else if (ev && (cnt + 1 == target)) begin
        last_status = ST_OK;
        fin = 1'b1;
      end else begin
        if (ev) cnt++;
        p_prev = p_cur;
        p_cur  = h;
        j++;
      end
    end
    bus.abort       = 1'b0;
    bus.hold        = 1'b0;
    bus.ctr_expired = 1'b0;
    check_outs({tag, ".done"}, 1'b0, last_preset, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, last_status, 1'b0);
    gap_tail(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    last_preset     = '0;
    last_status     = ST_OK;
    resetb          = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = '0;
    bus.cmd_preset  = '0;
    bus.cmd_reps    = '0;
    bus.hold        = 1'b0;
    bus.abort       = 1'b0;
    bus.ctr_expired = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_OK, 1'b0);
    resetb = 1'b1;
    tick();
    check_outs("reset.release", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_OK, 1'b1);

    do_load("load2a", 8'h2A, 1'b0);
    do_load("load5", 8'h05, 1'b0);
    do_run("up3", OP_UP, 8'd3, 0, 40, 0, 1'b0, 1'b0);
    do_run("dn2_hold", OP_DN, 8'd2, 0, 40, 0, 1'b0, 1'b1);
    do_run("up0", OP_UP, 8'd0, 20, 40, 0, 1'b0, 1'b0);
    do_run("up_b2b", OP_UP, 8'd1, 20, 40, 0, 1'b0, 1'b0);
    do_run("abort_final", OP_UP, 8'd3, 20, 40, 0, 1'b1, 1'b0);
    do_illegal("illegal");
    do_load("load_abort", 8'hC3, 1'b1);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(3))
        0: do_load("rnd_load", CNT_W'($urandom), rnd(15));
        1: do_run("rnd_up", OP_UP, REP_W'($urandom_range(4)), 20, 35, 3, 1'b0, 1'b0);
        2: do_run("rnd_dn", OP_DN, REP_W'($urandom_range(4)), 20, 35, 3, rnd(30), 1'b0);
        default: do_illegal("rnd_ill");
      endcase
    end

    // Reset in the middle of a long run
    send_cmd(OP_UP, 8'h00, 8'd200);
    tick();
    tick();
    check_eq("rst.up_before", 32'(bus.enable_cnt_up), 32'(1'b1));
    #2;
    resetb = 1'b0;
    #1;
    last_preset = '0;
    last_status = ST_OK;
    check_outs("rst.async", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_OK, 1'b0);
    @(posedge clk);
    #1;
    resetb = 1'b1;
    tick();
    check_outs("rst.release", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_OK, 1'b1);
    do_run("post_rst", OP_DN, 8'd2, 20, 40, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
